disposition_request_queue: RTL and testbench
============================================

# disposition_request_queue

Memory-request queue directly downstream of the Disposition stage. Each cycle it accepts up to three requests (self read, other read, write) and writes them into a FIFO in a fixed order. It then issues them one per cycle to the single-port shared-memory interface with a valid/ready handshake. While the FIFO lacks room for a worst-case cycle, it asserts `stall` back to the pipeline.

## Interface
Parameters:
- `DEPTH`, 8 — FIFO entries; power of two, ≥4.
- `ADDR_W`, 16 — request address width.
- `DATA_W`, 64 — write data width.
- `ID_W`, 8 — requesting thread id width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `rd1_valid`/`rd1_addr`/`rd1_id`  in  1/ADDR_W/ID_W  — read 1 (self read) from Disposition.
- `rd2_valid`/`rd2_addr`/`rd2_id`  in  1/ADDR_W/ID_W  — read 2 (other-thread read).
- `wr_valid`/`wr_addr`/`wr_data`  in  1/ADDR_W/DATA_W  — write request.
- `stall`  out  1  — asserted when free entries < 3.
- `mem_valid`  out  1  — head entry presented.
- `mem_ready`  in  1  — memory accepts the head entry this cycle.
- `mem_we`  out  1  — 1 = write, 0 = read.
- `mem_addr`/`mem_data`/`mem_id`  out  ADDR_W/DATA_W/ID_W  — head entry fields.
- `mem_src`  out  2  — origin: 0 = rd1, 1 = rd2, 2 = wr.
- `count`  out  $clog2(DEPTH)+1  — current occupancy.
- `overflow_err`  out  1  — sticky; set when a request cycle is dropped.

## Operation
- Entry = {we, src, addr, data, id}.
  - Read entries store `data` = 0.
  - Write entries store `id` = 0.
- Intra-cycle enqueue order: rd1, then rd2, then wr. Reads are therefore ordered before the same-cycle write.
- n_in = popcount(rd1_valid, rd2_valid, wr_valid), range 0..3.
- Accept rule: accept all when n_in ≤ DEPTH − count, using registered `count` only.
  - A same-cycle dequeue is not credited.
  - Otherwise drop all of the cycle's requests and set `overflow_err`.
  - Drops are all-or-nothing; no partial enqueue.
- Dequeue occurs when `mem_valid && mem_ready`.
- Next count = count + accepted_n − deq.
- Write pointer advances by accepted_n, read pointer by deq. Both are log2(DEPTH) bits and wrap modulo DEPTH.
- `stall` = (DEPTH − count) < 3, combinational from the `count` register.
- `mem_valid` = (count != 0).
- The head fields are driven from the read-pointer entry. They remain stable while `mem_valid && !mem_ready`.
- `overflow_err` clears only on `rst`.

## Timing
- Reset values:
  - `count` = 0, pointers = 0, `stall` = 0, `mem_valid` = 0, `overflow_err` = 0.
  - `mem_we`/`mem_addr`/`mem_data`/`mem_id`/`mem_src` = 0.
- `rst` asserted mid-operation discards all queued entries at that edge. Inputs during the `rst` cycle are ignored.
- Latency: a request sampled at edge N is visible at `mem_valid` after edge N at the earliest, i.e. 1 cycle when the queue is empty.
- Throughput is one dequeue per cycle. With a 3-request burst, the head is the rd1 entry, then rd2, then wr on consecutive ready cycles.
- Full with simultaneous dequeue and enqueue: the enqueue is still judged on pre-dequeue `count`.
- Empty with `mem_ready` high: no dequeue and `count` is unchanged.
- Handshake rule: once `mem_valid` rises it stays high until accepted. Head fields never change while waiting.

## Configuration
- `DISPOSITION_QUEUE_BYPASS_EN` defined:
  - When count = 0, n_in = 1 and `mem_ready` = 1, the single request is driven combinationally onto the `mem_*` outputs with `mem_valid` = 1 in the same cycle. It is not enqueued and `count` stays 0.
  - When any of those conditions fails, the normal enqueue path applies.
- Undefined: no combinational input-to-output path; minimum latency is 1 cycle.

## Test plan
- Reset: drive all valids high during `rst` → after release `count` = 0, `mem_valid` = 0, `stall` = 0, `overflow_err` = 0.
- Ordering: one cycle with rd1(addr 0x10, id 54), rd2(addr 0x20, id 7) and wr(addr 0x30, data 87), with `mem_ready` = 1 → three consecutive beats:
  - src 0 / 0x10 / id 54;
  - src 1 / 0x20 / id 7;
  - src 2 / we = 1 / data 87.
  - `count` steps 3→2→1→0.
- Backpressure: `mem_ready` = 0 with two 3-request cycles.
  - After them, `count` = 6 and `stall` = 1.
  - A third 3-request cycle (needs 3, free 2) is dropped: `count` stays 6 and `overflow_err` = 1.
  - Head fields stay at the first rd1 entry throughout.
- Wrap-around: stream 20 single writes with `mem_ready` toggling 1/0 → all 20 delivered in order with data 0..19 and no `overflow_err`.
- Simultaneous enqueue and dequeue at `count` = 6:
  - rd1+rd2 plus dequeue → `count` = 7.
  - Then a 2-request cycle plus dequeue at `count` = 7 → dropped (2 > 1 free) and `overflow_err` set.
- Bypass (macro on): empty queue, one rd1 (addr 0x40) with `mem_ready` = 1 → same-cycle `mem_valid` = 1 with addr 0x40, `count` stays 0. With the macro off, the same stimulus gives `mem_valid` one cycle later.

Source files
------------

// File: rtl/disposition_request_queue.sv
// Request FIFO between Disposition and the single-port shared memory: up to three
// requests in per cycle (rd1, rd2, wr), one out per cycle. Option: DISPOSITION_QUEUE_BYPASS_EN.
module disposition_request_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd1_valid,
  input  logic [ADDR_W-1:0]          rd1_addr,
  input  logic [ID_W-1:0]            rd1_id,
  input  logic                       rd2_valid,
  input  logic [ADDR_W-1:0]          rd2_addr,
  input  logic [ID_W-1:0]            rd2_id,
  input  logic                       wr_valid,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       stall,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic [ID_W-1:0]            mem_id,
  output logic [1:0]                 mem_src,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              we;
    logic [1:0]        src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  entry_t          w_rd1_e, w_rd2_e, w_wr_e, w_single_e, w_head, w_out;
  logic [1:0]      w_n_in;
  logic [CW-1:0]   w_free;
  logic            w_fits, w_acc, w_head_valid, w_deq, w_bypass;
  logic [1:0]      w_acc_n;
  logic [PW-1:0]   w_rd2_off, w_wr_off;

  assign w_rd1_e = '{we: 1'b0, src: 2'd0, addr: rd1_addr, data: '0, id: rd1_id};
  assign w_rd2_e = '{we: 1'b0, src: 2'd1, addr: rd2_addr, data: '0, id: rd2_id};
  assign w_wr_e  = '{we: 1'b1, src: 2'd2, addr: wr_addr, data: wr_data, id: '0};

  assign w_n_in       = 2'(rd1_valid) + 2'(rd2_valid) + 2'(wr_valid);
  assign w_free       = CW'(DEPTH) - r_count;
  // Room is judged on the registered count only; a same-cycle dequeue earns no credit.
  assign w_fits       = {{(CW-2){1'b0}}, w_n_in} <= w_free;
  assign w_head_valid = (r_count != '0);
  assign w_deq        = w_head_valid && mem_ready;

`ifdef DISPOSITION_QUEUE_BYPASS_EN
  assign w_bypass = !rst && !w_head_valid && (w_n_in == 2'd1) && mem_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_acc   = w_fits && !w_bypass && (w_n_in != 2'd0);
  assign w_acc_n = w_acc ? w_n_in : 2'd0;

  // Fixed slot order rd1, rd2, wr: each slot skips over absent predecessors.
  assign w_rd2_off = PW'(rd1_valid);
  assign w_wr_off  = PW'(rd1_valid) + PW'(rd2_valid);

  always_ff @(posedge clk) begin
    if (!rst && w_acc) begin
      if (rd1_valid) r_mem[r_wr_ptr]             <= w_rd1_e;
      if (rd2_valid) r_mem[r_wr_ptr + w_rd2_off] <= w_rd2_e;
      if (wr_valid)  r_mem[r_wr_ptr + w_wr_off]  <= w_wr_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_acc_n);
      r_rd_ptr <= r_rd_ptr + PW'(w_deq);
      r_count  <= r_count + CW'(w_acc_n) - CW'(w_deq);
      if (!w_fits && !w_bypass) r_overflow <= 1'b1;
    end
  end

  assign w_single_e = rd1_valid ? w_rd1_e : (rd2_valid ? w_rd2_e : w_wr_e);
  assign w_head     = r_mem[r_rd_ptr];
  // Head fields read as zero while empty so idle outputs match the reset state.
  assign w_out      = w_bypass ? w_single_e : (w_head_valid ? w_head : '0);

  assign mem_valid    = w_head_valid || w_bypass;
  assign mem_we       = w_out.we;
  assign mem_src      = w_out.src;
  assign mem_addr     = w_out.addr;
  assign mem_data     = w_out.data;
  assign mem_id       = w_out.id;
  assign count        = r_count;
  assign stall        = (w_free < CW'(3));
  assign overflow_err = r_overflow;
endmodule

// File: tb/tb_disposition_request_queue.sv
// Scoreboard bench for disposition_request_queue: a reference occupancy model pushes
// expected entries on acceptance and pops them as the memory side accepts beats.
module tb_disposition_request_queue;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int ID_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd1_valid, rd2_valid, wr_valid;
  logic [ADDR_W-1:0] rd1_addr, rd2_addr, wr_addr;
  logic [ID_W-1:0]   rd1_id, rd2_id;
  logic [DATA_W-1:0] wr_data;
  logic              stall, mem_valid, mem_ready, mem_we, overflow_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ID_W-1:0]   mem_id;
  logic [1:0]        mem_src;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] sb_q[$];
  int   mdl_count;
  logic mdl_ovf;

  disposition_request_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_id(rd1_id),
    .rd2_valid(rd2_valid), .rd2_addr(rd2_addr), .rd2_id(rd2_id),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .stall(stall), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_id(mem_id), .mem_src(mem_src),
    .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic we, input logic [1:0] src,
                                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                      input logic [ID_W-1:0] id);
    return {37'd0, we, src, a, d, id};
  endfunction

  function automatic logic [127:0] observed();
    return {37'd0, mem_we, mem_src, mem_addr, mem_data, mem_id};
  endfunction

  // One clock of stimulus; checks the DUT at the falling edge, then updates the model.
  task automatic cyc(input bit r1v, input int r1a, input int r1i,
                     input bit r2v, input int r2a, input int r2i,
                     input bit wv, input int wa, input longint wd, input bit rdy);
    int n;
    bit byp, deq, acc;
    logic [127:0] e1, e2, ew, eb;
    rd1_valid = r1v; rd1_addr = ADDR_W'(r1a); rd1_id = ID_W'(r1i);
    rd2_valid = r2v; rd2_addr = ADDR_W'(r2a); rd2_id = ID_W'(r2i);
    wr_valid  = wv;  wr_addr  = ADDR_W'(wa);  wr_data = DATA_W'(wd);
    mem_ready = rdy;
    e1 = mk(1'b0, 2'd0, ADDR_W'(r1a), '0, ID_W'(r1i));
    e2 = mk(1'b0, 2'd1, ADDR_W'(r2a), '0, ID_W'(r2i));
    ew = mk(1'b1, 2'd2, ADDR_W'(wa), DATA_W'(wd), '0);
    n = int'(r1v) + int'(r2v) + int'(wv);
`ifdef DISPOSITION_QUEUE_BYPASS_EN
    byp = (mdl_count == 0) && (n == 1) && rdy;
`else
    byp = 1'b0;
`endif
    eb = r1v ? e1 : (r2v ? e2 : ew);
    @(negedge clk);
    check("mem_valid", 128'(mem_valid), 128'(byp || (mdl_count != 0)));
    check("count", 128'(count), 128'(mdl_count));
    check("stall", 128'(stall), 128'((DEPTH - mdl_count) < 3));
    check("overflow_err", 128'(overflow_err), 128'(mdl_ovf));
    if (byp) check("bypass_beat", observed(), eb);
    else if (mdl_count != 0) check(rdy ? "beat" : "head_hold", observed(), sb_q[0]);
    @(posedge clk);
    if (!byp) begin
      deq = (mdl_count != 0) && rdy;
      acc = (n <= DEPTH - mdl_count);
      if (deq) void'(sb_q.pop_front());
      if (acc) begin
        if (r1v) sb_q.push_back(e1);
        if (r2v) sb_q.push_back(e2);
        if (wv)  sb_q.push_back(ew);
        mdl_count += n;
      end else begin
        mdl_ovf = 1'b1;
      end
      mdl_count -= int'(deq);
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic burst3(input int base, input bit rdy);
    cyc(1, base + 1, base + 2, 1, base + 3, base + 4, 1, base + 5, longint'(base + 6), rdy);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rd1_valid = 1'b1; rd2_valid = 1'b1; wr_valid = 1'b1; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; rd1_valid = 1'b0; rd2_valid = 1'b0; wr_valid = 1'b0;
    sb_q.delete(); mdl_count = 0; mdl_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0;
    rd1_valid = 0; rd2_valid = 0; wr_valid = 0;
    rd1_addr = '0; rd2_addr = '0; wr_addr = '0; rd1_id = '0; rd2_id = '0; wr_data = '0;
    mdl_count = 0; mdl_ovf = 1'b0;

    // Reset with all valids high, then confirm idle state and zeroed head.
    do_reset();
    @(negedge clk);
    check("rst_count", 128'(count), 128'(0));
    check("rst_mem_valid", 128'(mem_valid), 128'(0));
    check("rst_stall", 128'(stall), 128'(0));
    check("rst_overflow", 128'(overflow_err), 128'(0));
    check("rst_head", observed(), 128'(0));
    @(posedge clk); #1;
    $display("txn reset done");

    // Ordering: rd1, rd2, wr from one cycle leave in that order.
    cyc(1, 'h10, 54, 1, 'h20, 7, 1, 'h30, 87, 1);
    for (int i = 0; i < 4; i++) idle(1);
    $display("txn ordering done count=%0d", mdl_count);

    // Backpressure: fill to 6, third burst dropped, head held.
    burst3(100, 0);
    burst3(200, 0);
    burst3(300, 0);
    idle(0);
    $display("txn backpressure count=%0d ovf=%0b", mdl_count, mdl_ovf);
    for (int i = 0; i < 7; i++) idle(1);
    do_reset();

    // Wrap-around: 20 single writes with toggling ready.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 'h400 + i, longint'(i), 1'(i % 2));
      idle(1'((i + 1) % 2));
    end
    for (int i = 0; i < 12; i++) idle(1);
    check("wrap_drained", 128'(sb_q.size()), 128'(0));
    $display("txn wrap done ovf=%0b", overflow_err);

    // Enqueue plus dequeue at count 6, then at count 7.
    burst3(500, 0);
    burst3(600, 0);
    cyc(1, 'h71, 1, 1, 'h72, 2, 0, 0, 0, 1);
    cyc(1, 'h81, 3, 1, 'h82, 4, 0, 0, 0, 1);
    idle(0);
    $display("txn simul count=%0d ovf=%0b", mdl_count, mdl_ovf);
    for (int i = 0; i < 8; i++) idle(1);
    do_reset();

    // Single read into an empty queue with ready high.
    cyc(1, 'h40, 9, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    idle(1);
    $display("txn single-read done count=%0d", mdl_count);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
